// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types for the generic SPI master.
//   spi_state_e : transfer sequencer states
//   MODE0..3    : SPI mode encoding as {cpol, cpha}
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_FIN   = 3'd4
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// Half-period down-counter and sclk edge strobes for the SPI master.
//   clk, rst      : system clock, async active-high reset
//   i_en          : counter runs (LEAD/SHIFT/TRAIL); otherwise held at reload
//   i_shift       : SHIFT phase; edge strobes and lead/trail phase only here
//   o_tick        : terminal count, one pulse every CLK_DIV cycles while i_en
//   o_lead_edge   : tick that moves sclk away from cpol
//   o_trail_edge  : tick that returns sclk to cpol
// ---------------------------------------------------------------------------
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_shift,
  output logic o_tick,
  output logic o_lead_edge,
  output logic o_trail_edge
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_phase;   // 0: next edge is leading, 1: next edge is trailing

  assign o_tick       = i_en && (r_cnt == 8'd0);
  assign o_lead_edge  = o_tick && i_shift && !r_phase;
  assign o_trail_edge = o_tick && i_shift && r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 8'd0;
      r_phase <= 1'b0;
    end else begin
      if (!i_en || r_cnt == 8'd0) r_cnt <= RELOAD;
      else                        r_cnt <= r_cnt - 8'd1;

      if (!i_shift)    r_phase <= 1'b0;
      else if (o_tick) r_phase <= !r_phase;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// ---------------------------------------------------------------------------
// spi_master_gen
// Generic single-word SPI master, modes 0-3, MSB/LSB first, NUM_SS selects.
//   clk, rst        : system clock, async active-high reset
//   start           : transfer request, taken only in IDLE with a valid ss_sel
//   cpol, cpha, lsb_first, ss_sel, tx_data : latched when start is taken
//   miso            : serial input from the slave
//   sclk, mosi      : SPI clock and serial output
//   ss_n            : active-low selects, one-hot low during a transfer
//   busy            : from acceptance through the done cycle
//   done            : one-cycle completion pulse, rx_data valid with it
//   rx_data         : received word, held until the next done
//
// state    | meaning
// ST_IDLE  | waiting; sclk tracks cpol input, ss_n all high
// ST_LEAD  | slave selected, CLK_DIV cycles of setup before first edge
// ST_SHIFT | 2*DATA_W sclk edges, shift out/sample in
// ST_TRAIL | sclk parked at cpol, slave still selected for CLK_DIV cycles
// ST_FIN   | deselect, publish rx_data, pulse done on the next cycle
// ---------------------------------------------------------------------------
module spi_master_gen
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int CLK_DIV = 2,
  parameter  int NUM_SS  = 4,
  localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  spi_state_e        r_state;
  logic              r_cpha;
  logic              r_lsb_first;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [5:0]        r_bit_cnt;
  logic              r_sclk;
  logic              r_mosi;
  logic [NUM_SS-1:0] r_ss_n;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rx_data;

  logic              w_run;
  logic              w_shift;
  logic              w_tick;
  logic              w_lead_edge;
  logic              w_trail_edge;
  logic              w_accept;
  logic              w_first_bit;
  logic [DATA_W-1:0] w_tx_load;
  logic              w_tx_bit;
  logic [DATA_W-1:0] w_tx_next;
  logic [DATA_W-1:0] w_rx_next;
  logic              w_last;

  assign w_run   = (r_state == ST_LEAD) || (r_state == ST_SHIFT) || (r_state == ST_TRAIL);
  assign w_shift = (r_state == ST_SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_run),
    .i_shift      (w_shift),
    .o_tick       (w_tick),
    .o_lead_edge  (w_lead_edge),
    .o_trail_edge (w_trail_edge)
  );

  // r_tx always holds the bits not yet driven; the first bit is taken from
  // the input directly for cpha=0 because it must be on mosi during LEAD.
  always_comb begin
    w_accept    = start && (int'(ss_sel) < NUM_SS);
    w_first_bit = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    w_tx_load   = lsb_first ? (tx_data >> 1) : (tx_data << 1);
    w_tx_bit    = r_lsb_first ? r_tx[0] : r_tx[DATA_W-1];
    w_tx_next   = r_lsb_first ? (r_tx >> 1) : (r_tx << 1);
    // Shifting in from the side opposite to the first bit lands sample k on bit k.
    w_rx_next   = r_lsb_first ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
    w_last      = (r_bit_cnt == 6'(DATA_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cpha      <= 1'b0;
      r_lsb_first <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_bit_cnt   <= 6'd0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_ss_n      <= '1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rx_data   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= cpol;
          r_mosi <= 1'b0;
          r_ss_n <= '1;
          // busy stays up through the done cycle, then drops unless a
          // back-to-back start is taken here
          r_busy <= w_accept;
          if (w_accept) begin
            r_state     <= ST_LEAD;
            r_cpha      <= cpha;
            r_lsb_first <= lsb_first;
            r_ss_n      <= ~(NUM_SS'(1) << ss_sel);
            r_mosi      <= cpha ? 1'b0 : w_first_bit;
            r_tx        <= cpha ? tx_data : w_tx_load;
            r_rx        <= '0;
            r_bit_cnt   <= 6'd0;
          end
        end
        ST_LEAD: begin
          if (w_tick) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_lead_edge) begin
            r_sclk <= !r_sclk;
            if (!r_cpha) begin
              r_rx <= w_rx_next;
            end else begin
              r_mosi <= w_tx_bit;
              r_tx   <= w_tx_next;
            end
          end
          if (w_trail_edge) begin
            r_sclk    <= !r_sclk;
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_cpha) begin
              r_rx <= w_rx_next;
            end else if (!w_last) begin
              r_mosi <= w_tx_bit;
              r_tx   <= w_tx_next;
            end
            if (w_last) r_state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (w_tick) begin
            r_state <= ST_FIN;
            r_ss_n  <= '1;
          end
        end
        ST_FIN: begin
          r_state   <= ST_IDLE;
          r_done    <= 1'b1;
          r_rx_data <= r_rx;
          r_mosi    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign ss_n    = r_ss_n;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_gen.sv
// ---------------------------------------------------------------------------
// tb_spi_master_gen
// Directed bench for spi_master_gen (DATA_W=8, CLK_DIV=2, NUM_SS=5).
// Five selects give a 3-bit ss_sel, so ss_sel=5 is an encodable, out-of-range
// index (a 4-select build only has a 2-bit select that cannot express 5).
// ---------------------------------------------------------------------------
module tb_spi_master_gen;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [2:0] ss_sel = 3'd0;
  logic [7:0] tx_data = 8'h00;
  logic       miso;
  logic       sclk, mosi, busy, done;
  logic [4:0] ss_n;
  logic [7:0] rx_data;

  logic use_slave = 1'b0;
  logic slave_bit = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign miso = use_slave ? slave_bit : mosi;

  spi_master_gen #(
    .DATA_W  (8),
    .CLK_DIV (2),
    .NUM_SS  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .ss_sel    (ss_sel),
    .tx_data   (tx_data),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One transfer. lat counts rising edges after the one that samples start
  // (-1 if no done within the window). cap assembles mosi at the slave's
  // sampling edges in the chosen bit order. A glitch at cycle glitch_n
  // pulses start and disturbs the other inputs mid-transfer.
  task automatic xfer(input logic [1:0] mode, input logic lsb, input logic [2:0] sel,
                      input logic [7:0] tx, input logic slv, input logic [7:0] slv_word,
                      input int glitch_n,
                      output int lat, output logic [7:0] cap, output int edges,
                      output int ss_cnt, output logic [4:0] ss_and, output logic busy_any);
    logic       prev;
    logic       lead;
    logic [7:0] sl;
    @(negedge clk);
    cpol = mode[1]; cpha = mode[0]; lsb_first = lsb; ss_sel = sel; tx_data = tx;
    use_slave = slv; sl = slv_word; slave_bit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; cap = 8'h00; edges = 0; ss_cnt = 0; ss_and = 5'h1f; busy_any = 1'b0;
    prev = sclk;
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (n == glitch_n) begin
        start = 1'b1; tx_data = 8'hFF; lsb_first = ~lsb; ss_sel = 3'd1;
      end else if (n == glitch_n + 1) begin
        start = 1'b0;
      end
      if (ss_n != 5'h1f) ss_cnt++;
      ss_and = ss_and & ss_n;
      if (busy) busy_any = 1'b1;
      if (sclk !== prev && ss_n != 5'h1f) begin
        edges++;
        lead = (sclk != mode[1]);
        if (lead == !mode[0]) cap = lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
        if (slv && lead && mode[0]) begin
          slave_bit = sl[7];
          sl = sl << 1;
        end
      end
      prev = sclk;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  int         lat, edges, ss_cnt, n_done;
  logic [7:0] cap;
  logic [4:0] ss_and;
  logic       busy_any;

  initial begin
    // reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_sclk_mosi_busy_done", 32'({sclk, mosi, busy, done}), 32'h0);
    chk("rst_ss_n", 32'(ss_n), 32'h1f);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle sclk follows cpol input
    @(negedge clk) cpol = 1'b1;
    @(posedge clk) #1;
    chk("idle_sclk_cpol1", 32'({sclk, mosi}), 32'h2);
    @(negedge clk) cpol = 1'b0;
    @(posedge clk) #1;
    chk("idle_sclk_cpol0", 32'(sclk), 32'h0);

    // mode 0, MSB first, 0xA5 looped back on select 0
    xfer(MODE0, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, -10, lat, cap, edges, ss_cnt, ss_and, busy_any);
    chk("m0_latency", 32'(lat), 32'd37);
    chk("m0_rx", 32'(rx_data), 32'hA5);
    chk("m0_mosi", 32'(cap), 32'hA5);
    chk("m0_edges", 32'(edges), 32'd16);
    chk("m0_ss_cycles", 32'(ss_cnt), 32'd36);
    chk("m0_ss_and", 32'(ss_and), 32'h1e);
    chk("m0_busy_at_done", 32'({busy, ss_n}), 32'h3f);
    @(posedge clk) #1;
    chk("m0_after_done", 32'({busy, done}), 32'h0);

    // mode 3, select 2, slave answers 0xC3
    xfer(MODE3, 1'b0, 3'd2, 8'h3C, 1'b1, 8'hC3, -10, lat, cap, edges, ss_cnt, ss_and, busy_any);
    chk("m3_latency", 32'(lat), 32'd37);
    chk("m3_rx", 32'(rx_data), 32'hC3);
    chk("m3_mosi", 32'(cap), 32'h3C);
    chk("m3_ss_and", 32'(ss_and), 32'h1b);
    chk("m3_edges", 32'(edges), 32'd16);

    // mode 1, LSB first, single set bit
    xfer(MODE1, 1'b1, 3'd0, 8'h01, 1'b0, 8'h00, -10, lat, cap, edges, ss_cnt, ss_and, busy_any);
    chk("m1_lsb_mosi", 32'(cap), 32'h01);
    chk("m1_lsb_rx", 32'(rx_data), 32'h01);

    // mode 0, LSB first, asymmetric word
    xfer(MODE0, 1'b1, 3'd4, 8'h1E, 1'b0, 8'h00, -10, lat, cap, edges, ss_cnt, ss_and, busy_any);
    chk("m0_lsb_mosi", 32'(cap), 32'h1E);
    chk("m0_lsb_rx", 32'(rx_data), 32'h1E);
    chk("m0_lsb_ss_and", 32'(ss_and), 32'h0f);

    // start and input changes during SHIFT leave the transfer alone
    xfer(MODE0, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, 10, lat, cap, edges, ss_cnt, ss_and, busy_any);
    chk("busy_start_latency", 32'(lat), 32'd37);
    chk("busy_start_rx", 32'(rx_data), 32'hA5);
    chk("busy_start_ss_and", 32'(ss_and), 32'h1e);
    n_done = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk) #1;
      if (done) n_done++;
    end
    chk("busy_start_extra_done", 32'(n_done), 32'd0);

    // out-of-range select is ignored
    xfer(MODE0, 1'b0, 3'd5, 8'h5A, 1'b0, 8'h00, -10, lat, cap, edges, ss_cnt, ss_and, busy_any);
    chk("bad_sel_no_done", 32'(lat), 32'hffffffff);
    chk("bad_sel_busy", 32'(busy_any), 32'h0);
    chk("bad_sel_ss_n", 32'(ss_and), 32'h1f);
    chk("bad_sel_rx_held", 32'(rx_data), 32'hA5);

    // reset in the middle of SHIFT
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; ss_sel = 3'd0; tx_data = 8'hA5; use_slave = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", 32'({busy, sclk, ss_n}), 32'h7e);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", 32'({sclk, mosi, busy, done}), 32'h0);
    chk("mid_rst_ss_n", 32'(ss_n), 32'h1f);
    chk("mid_rst_rx", 32'(rx_data), 32'h0);
    @(negedge clk) rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk) #1;
      if (done) n_done++;
    end
    chk("mid_rst_no_done", 32'(n_done), 32'd0);
    xfer(MODE0, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, -10, lat, cap, edges, ss_cnt, ss_and, busy_any);
    chk("post_rst_latency", 32'(lat), 32'd37);
    chk("post_rst_rx", 32'(rx_data), 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
